// File: rtl/frame_extrema_tracker_pkg.sv
// Shared definitions for the frame extrema tracker slice.
package frame_extrema_tracker_pkg;

    localparam int unsigned DATA_W        = 8;
    localparam int unsigned IDX_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } fet_state_t;

endpackage

// File: rtl/eight_bit_comparator.sv
// Unsigned 8-bit magnitude comparator; exactly one of less/equal/greater is set.
module eight_bit_comparator
    import frame_extrema_tracker_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              less,
    output logic              equal,
    output logic              greater
);

    // Word compare of a against b.
    always_comb begin
        less    = (a <  b);
        equal   = (a == b);
        greater = (a >  b);
    end

endmodule

// File: rtl/frame_extrema_tracker.sv
// Scans a framed stream of unsigned samples and reports max/min, their first
// indices, the sample count and whether the frame was force-closed at full length.
module frame_extrema_tracker
    import frame_extrema_tracker_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        max_val,
    output logic [IDX_W-1:0]  max_idx,
    output logic [7:0]        min_val,
    output logic [IDX_W-1:0]  min_idx,
    output logic [IDX_W:0]    count,
    output logic              overflow
);

    localparam logic [IDX_W:0] FRAME_MAX = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W:0] COUNT_ONE = {{IDX_W{1'b0}}, 1'b1};

    fet_state_t      state;
    fet_state_t      state_next;
    logic            accept;
    logic            release_result;
    logic [IDX_W:0]  count_inc;
    logic            frame_full;

    logic max_lt, max_eq, max_gt;
    logic min_lt, min_eq, min_gt;
    logic max_update, min_update;

    eight_bit_comparator u_cmp_max (
        .a       (in_data),
        .b       (max_val),
        .less    (max_lt),
        .equal   (max_eq),
        .greater (max_gt)
    );

    eight_bit_comparator u_cmp_min (
        .a       (in_data),
        .b       (min_val),
        .less    (min_lt),
        .equal   (min_eq),
        .greater (min_gt)
    );

    // Strict compare only: an equal sample keeps the earlier index.
    always_comb begin
        max_update = max_gt & ~(max_eq | max_lt);
        min_update = min_lt & ~(min_eq | min_gt);
        count_inc  = count + COUNT_ONE;
        frame_full = (count_inc == FRAME_MAX);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake decode and next-state selection.
    always_comb begin
        state_next     = state;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        accept         = 1'b0;
        release_result = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_next = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && (in_last || frame_full)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid      = 1'b1;
                release_result = out_ready;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Running extrema, index and count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_val  <= '0;
            min_val  <= '0;
            max_idx  <= '0;
            min_idx  <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (accept && state == IDLE) begin
            max_val <= in_data;
            min_val <= in_data;
            max_idx <= '0;
            min_idx <= '0;
            count   <= COUNT_ONE;
        end else if (accept) begin
            if (max_update) begin
                max_val <= in_data;
                max_idx <= count[IDX_W-1:0];
            end
            if (min_update) begin
                min_val <= in_data;
                min_idx <= count[IDX_W-1:0];
            end
            count <= count_inc;
            if (frame_full) begin
                overflow <= 1'b1;
            end
        end else if (release_result) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_extrema_tracker.sv
// Directed bench for frame_extrema_tracker with hand-computed expectations.
module tb_frame_extrema_tracker;

    localparam int unsigned IDX_W = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       max_val;
    logic [IDX_W-1:0] max_idx;
    logic [7:0]       min_val;
    logic [IDX_W-1:0] min_idx;
    logic [IDX_W:0]   count;
    logic             overflow;

    int n_tests = 0;
    int n_fail  = 0;

    frame_extrema_tracker #(.IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .max_val   (max_val),
        .max_idx   (max_idx),
        .min_val   (min_val),
        .min_idx   (min_idx),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [7:0] mx, input logic [3:0] mxi,
                                input logic [7:0] mn, input logic [3:0] mni,
                                input logic [4:0] cnt, input logic ovf);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".in_ready"},  32'(in_ready),  32'd0);
        check({tag, ".max_val"},   32'(max_val),   32'(mx));
        check({tag, ".max_idx"},   32'(max_idx),   32'(mxi));
        check({tag, ".min_val"},   32'(min_val),   32'(mn));
        check({tag, ".min_idx"},   32'(min_idx),   32'(mni));
        check({tag, ".count"},     32'(count),     32'(cnt));
        check({tag, ".overflow"},  32'(overflow),  32'(ovf));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".max_val"},   32'(max_val),   32'd0);
        check({tag, ".min_val"},   32'(min_val),   32'd0);
        check({tag, ".max_idx"},   32'(max_idx),   32'd0);
        check({tag, ".min_idx"},   32'(min_idx),   32'd0);
        check({tag, ".count"},     32'(count),     32'd0);
        check({tag, ".overflow"},  32'(overflow),  32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        check_reset_vals("rst");
        reset = 1'b0;
        tick();

        // Frame 5, 200, 17, 200 with consumer always ready.
        out_ready = 1'b1;
        accept(8'd5, 1'b0);
        check("f1.mid_out_valid", 32'(out_valid), 32'd0);
        accept(8'd200, 1'b0);
        accept(8'd17, 1'b0);
        accept(8'd200, 1'b1);
        check_result("f1", 8'd200, 4'd1, 8'd5, 4'd0, 5'd4, 1'b0);
        tick();
        check("f1.consumed_out_valid", 32'(out_valid), 32'd0);
        check("f1.consumed_in_ready",  32'(in_ready),  32'd1);

        // Single-sample frame.
        out_ready = 1'b0;
        accept(8'h80, 1'b1);
        check_result("single", 8'h80, 4'd0, 8'h80, 4'd0, 5'd1, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single.idle_out_valid", 32'(out_valid), 32'd0);
        check("single.idle_in_ready",  32'(in_ready),  32'd1);

        // Backpressure: result held while a sample waits.
        accept(8'hFF, 1'b0);
        accept(8'h00, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h33;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_result("bp.hold", 8'hFF, 4'd0, 8'h00, 4'd1, 5'd2, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp.release_out_valid", 32'(out_valid), 32'd0);
        check("bp.release_count",     32'(count),     32'd2);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ready = 1'b0;
        check_result("bp.next", 8'h33, 4'd0, 8'h33, 4'd0, 5'd1, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Full-length frame force-closed with overflow.
        for (int i = 0; i < 16; i++) begin
            accept(8'(i), 1'b0);
            if (i == 14) check("ovf.pre_out_valid", 32'(out_valid), 32'd0);
        end
        check_result("ovf", 8'd15, 4'd15, 8'd0, 4'd0, 5'd16, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ovf.cleared", 32'(overflow), 32'd0);
        check("ovf.idle_out_valid", 32'(out_valid), 32'd0);
        accept(8'd42, 1'b1);
        check_result("ovf.next", 8'd42, 4'd0, 8'd42, 4'd0, 5'd1, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset mid-frame.
        accept(8'd10, 1'b0);
        accept(8'd20, 1'b0);
        check("mid.count_before_reset", 32'(count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        #1;
        reset = 1'b0;
        tick();
        check("after_rst.out_valid", 32'(out_valid), 32'd0);
        accept(8'd9, 1'b0);
        accept(8'd3, 1'b1);
        check_result("after_rst", 8'd9, 4'd0, 8'd3, 4'd1, 5'd2, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Equal samples with idle gaps.
        accept(8'd7, 1'b0);
        tick();
        tick();
        check("gap.in_ready",  32'(in_ready),  32'd1);
        check("gap.out_valid", 32'(out_valid), 32'd0);
        check("gap.count",     32'(count),     32'd1);
        accept(8'd7, 1'b0);
        tick();
        tick();
        accept(8'd7, 1'b1);
        check_result("gap", 8'd7, 4'd0, 8'd7, 4'd0, 5'd3, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("gap.consumed", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
